cnn_layer_sequencer: RTL and testbench
======================================

# cnn_layer_sequencer

Control block that sits beside `cnn_mem` and runs the CNN inference once the host has loaded the input image and all weight banks. It waits until every bank reports loaded, then fires each layer engine in order (conv1, conv2, fc3, fc4). Between layers it pulses a ping-pong buffer swap, and it supervises each layer with a watchdog. The host reaches it through a small register window on the same 8-bit Avalon-style bus; completion or error raises `irq`.

## Interface
Parameters:
- `NUM_LAYERS`, 4: number of sequenced layer engines.
- `TMO_W`, 24: watchdog counter width.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `chipselect` in 1: register window select.
- `write` in 1: register write strobe.
- `read` in 1: register read strobe.
- `address` in 2: register index.
- `writedata` in 8: write data.
- `readdata` out 8: registered read data.
- `loaded` in NUM_LAYERS+1: bit 0 = input image loaded, bit k = layer k weights loaded; level signals.
- `layer_start` out NUM_LAYERS: one-hot, one-cycle start pulse.
- `layer_done` in NUM_LAYERS: one-cycle done pulse from each engine.
- `buf_swap` out 1: one-cycle pulse; swaps input/output activation buffers.
- `irq` out 1: level; set on DONE or ERROR entry, cleared by host.

## Operation
Registers:
- 0 CTRL (write-only, self-clearing): bit0 GO, bit1 ABORT, bit2 IRQ_CLR.
- 1 STATUS (read): [2:0] state code, [4:3] current layer index, bit5 done, bit6 error, bit7 irq.
- 2 TMO (read/write): watchdog limit = {TMO, 16'h0000} cycles; reset value 8'hFF; 0 disables the watchdog.
- 3 ERRCODE (read): 0 none, 1 timeout, 2 unexpected done, 3 abort.

States (code):
- IDLE(0): GO → WAIT_LOAD; clears done, error, ERRCODE, layer index.
- WAIT_LOAD(1): &`loaded` → START.
- START(2): assert `layer_start[idx]` for exactly one cycle; clear watchdog → RUN.
- RUN(3):
  - `layer_done[idx]` → SWAP.
  - Any `layer_done[j]` with j≠idx → ERROR (code 2), even if coincident with `layer_done[idx]`.
  - Watchdog reaches the limit → ERROR (code 1).
- SWAP(4): `buf_swap` for one cycle; if idx == NUM_LAYERS-1 → DONE, else idx+1 → START.
- DONE(5): done=1, irq=1; GO → WAIT_LOAD, a rerun without reloading.
- ERROR(6): error=1, irq=1; only GO leaves it (→ WAIT_LOAD, error cleared).

Other rules:
- ABORT in any non-IDLE state → ERROR (code 3) next cycle. ABORT has priority over GO written in the same byte.
- `layer_done` pulses are ignored outside RUN.
- GO in WAIT_LOAD, START, RUN or SWAP is ignored.
- IRQ_CLR clears `irq` only; it does not change state.
- Loss of any `loaded` bit outside WAIT_LOAD is not checked.

## Timing
- Reset values: state IDLE, idx 0, `layer_start` 0, `buf_swap` 0, `irq` 0, `readdata` 0, TMO 8'hFF, ERRCODE 0.
- Register write takes effect the cycle after the bus strobe.
- Read latency is 1: `readdata` is valid the cycle after `chipselect&&read`; otherwise it holds its last value.
- `loaded` all-high at cycle t (in WAIT_LOAD) → `layer_start[0]` high at t+2 (WAIT_LOAD→START at t+1, pulse in START).
- `layer_done[idx]` at t → `buf_swap` at t+2 → next `layer_start` at t+3.
- Watchdog counts every RUN cycle starting at 0. With TMO=1, ERROR is entered exactly 65536 cycles after entering RUN, unless done arrives first. A done arriving on the limit cycle wins.
- `reset` mid-run forces IDLE next edge; all pulses deassert immediately.

## Structure
- Package `cnn_pkg`: `seq_state_t` enum with the codes above, register address constants, ERRCODE constants, `NUM_LAYERS`.
- Sub-module `seq_watchdog`: loadable TMO_W counter with clear, enable, limit and `expired` outputs.
- The FSM and register file live in the top.

## Test plan
- Load all bits, GO; return each `layer_done` 10 cycles after its start → 4 starts in order 0..3, 3 swaps between layers plus 1 final, DONE, STATUS=8'hA5, irq=1.
- GO with `loaded`=5'b10111 for 50 cycles, then set bit 3 → no `layer_start` until 2 cycles after bit 3 rises.
- TMO=1, layer 1 never done → ERROR exactly 65536 cycles after its start; ERRCODE=1, irq=1.
- During layer 0 RUN, pulse `layer_done[2]` → ERROR, ERRCODE=2; a subsequent `layer_done[0]` is ignored.
- ABORT in RUN of layer 2 → ERROR, ERRCODE=3. Then IRQ_CLR → irq=0 with state still ERROR. Then GO → full rerun completes.
- Assert `reset` in SWAP → next cycle state IDLE, `buf_swap`=0, TMO=8'hFF.

Source files
------------

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared types and constants for the CNN layer sequencer
package cnn_pkg;

    localparam int NUM_LAYERS = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOAD = 3'd1,
        ST_START     = 3'd2,
        ST_RUN       = 3'd3,
        ST_SWAP      = 3'd4,
        ST_DONE      = 3'd5,
        ST_ERROR     = 3'd6
    } seq_state_t;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_TMO     = 2'd2;
    localparam logic [1:0] ADDR_ERRCODE = 2'd3;

    localparam int CTRL_GO_BIT      = 0;
    localparam int CTRL_ABORT_BIT   = 1;
    localparam int CTRL_IRQ_CLR_BIT = 2;

    localparam logic [1:0] ERR_NONE       = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT    = 2'd1;
    localparam logic [1:0] ERR_UNEXP_DONE = 2'd2;
    localparam logic [1:0] ERR_ABORT      = 2'd3;

    localparam logic [7:0] TMO_RESET = 8'hFF;

endpackage

// File: rtl/seq_watchdog.sv
// rtl/seq_watchdog.sv - per-layer watchdog counter with clear, enable and limit compare
module seq_watchdog #(
    parameter int TMO_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [TMO_W-1:0] limit,
    output logic             expired
);

    logic [TMO_W-1:0] count_q;
    logic [TMO_W-1:0] count_d;
    logic [TMO_W:0]   count_next;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires on the RUN cycle whose count is limit-1, so the FSM leaves RUN exactly
    // limit cycles after entering it; >= keeps it firing if the limit shrinks mid-run.
    assign count_next = {1'b0, count_q} + {{TMO_W{1'b0}}, 1'b1};
    assign expired    = enable && (limit != '0) && (count_next >= {1'b0, limit});

endmodule

// File: rtl/cnn_layer_sequencer.sv
// rtl/cnn_layer_sequencer.sv - runs the CNN layer engines in order with buffer swaps, watchdog and host registers
module cnn_layer_sequencer #(
    parameter int NUM_LAYERS = cnn_pkg::NUM_LAYERS,
    parameter int TMO_W      = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  chipselect,
    input  logic                  write,
    input  logic                  read,
    input  logic [1:0]            address,
    input  logic [7:0]            writedata,
    output logic [7:0]            readdata,
    input  logic [NUM_LAYERS:0]   loaded,
    output logic [NUM_LAYERS-1:0] layer_start,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic                  buf_swap,
    output logic                  irq
);
    import cnn_pkg::*;

    localparam logic [1:0] LAST_IDX = 2'(NUM_LAYERS - 1);

    seq_state_t            state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [1:0]            errcode_q, errcode_d;
    logic [7:0]            tmo_q, tmo_d;
    logic                  irq_q, irq_d;
    logic [7:0]            readdata_q, readdata_d;
    logic [NUM_LAYERS-1:0] layer_start_q, layer_start_d;
    logic                  buf_swap_q, buf_swap_d;

    logic                  ctrl_wr, go, abort, irq_clr;
    logic [NUM_LAYERS-1:0] cur_mask;
    logic                  own_done, other_done;
    logic                  wd_clear, wd_enable, wd_expired;
    logic [TMO_W-1:0]      wd_limit;
    logic [7:0]            status;

    assign ctrl_wr = chipselect && write && (address == ADDR_CTRL);
    assign abort   = ctrl_wr && writedata[CTRL_ABORT_BIT];
    assign go      = ctrl_wr && writedata[CTRL_GO_BIT] && !writedata[CTRL_ABORT_BIT];
    assign irq_clr = ctrl_wr && writedata[CTRL_IRQ_CLR_BIT];

    assign cur_mask   = NUM_LAYERS'(1) << idx_q;
    assign own_done   = |(layer_done & cur_mask);
    assign other_done = |(layer_done & ~cur_mask);
    assign wd_limit   = TMO_W'({tmo_q, 16'h0000});

    seq_watchdog #(
        .TMO_W (TMO_W)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .limit   (wd_limit),
        .expired (wd_expired)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        errcode_d = errcode_q;
        wd_clear  = 1'b0;
        wd_enable = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (go) begin
                    state_d   = ST_WAIT_LOAD;
                    idx_d     = '0;
                    errcode_d = ERR_NONE;
                end
            end
            ST_WAIT_LOAD: begin
                if (&loaded) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                wd_clear = 1'b1;
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                wd_enable = 1'b1;
                // A stray done from another engine outranks our own; our own done outranks the watchdog.
                if (other_done) begin
                    state_d   = ST_ERROR;
                    errcode_d = ERR_UNEXP_DONE;
                end else if (own_done) begin
                    state_d = ST_SWAP;
                end else if (wd_expired) begin
                    state_d   = ST_ERROR;
                    errcode_d = ERR_TIMEOUT;
                end
            end
            ST_SWAP: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    idx_d   = '0;
                end else begin
                    state_d = ST_START;
                    idx_d   = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort && (state_q != ST_IDLE)) begin
            state_d   = ST_ERROR;
            idx_d     = idx_q;
            errcode_d = ERR_ABORT;
        end
    end

    // Output pulses are registered, so they trail the START/SWAP state by one cycle.
    always_comb begin
        layer_start_d = (state_q == ST_START) ? cur_mask : '0;
        buf_swap_d    = (state_q == ST_SWAP);
        irq_d         = irq_q;
        if (irq_clr) begin
            irq_d = 1'b0;
        end
        if ((state_d != state_q) && ((state_d == ST_DONE) || (state_d == ST_ERROR))) begin
            irq_d = 1'b1;
        end
        tmo_d = tmo_q;
        if (chipselect && write && (address == ADDR_TMO)) begin
            tmo_d = writedata;
        end
    end

    assign status = {irq_q, (state_q == ST_ERROR), (state_q == ST_DONE), idx_q, state_q};

    always_comb begin
        readdata_d = readdata_q;
        if (chipselect && read) begin
            case (address)
                ADDR_STATUS:  readdata_d = status;
                ADDR_TMO:     readdata_d = tmo_q;
                ADDR_ERRCODE: readdata_d = {6'b0, errcode_q};
                default:      readdata_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            errcode_q     <= ERR_NONE;
            tmo_q         <= TMO_RESET;
            irq_q         <= 1'b0;
            readdata_q    <= 8'h00;
            layer_start_q <= '0;
            buf_swap_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            errcode_q     <= errcode_d;
            tmo_q         <= tmo_d;
            irq_q         <= irq_d;
            readdata_q    <= readdata_d;
            layer_start_q <= layer_start_d;
            buf_swap_q    <= buf_swap_d;
        end
    end

    assign readdata    = readdata_q;
    assign layer_start = layer_start_q;
    assign buf_swap    = buf_swap_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb/tb_cnn_layer_sequencer.sv - directed self-checking bench for cnn_layer_sequencer
module tb_cnn_layer_sequencer;

    logic       clk;
    logic       reset;
    logic       chipselect;
    logic       write;
    logic       read;
    logic [1:0] address;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic [4:0] loaded;
    logic [3:0] layer_start;
    logic [3:0] layer_done;
    logic       buf_swap;
    logic       irq;

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;

    logic       auto_en    = 1'b0;
    logic [3:0] never_mask = 4'b0000;
    logic       due_valid  = 1'b0;
    int         due_cycle  = 0;
    int         due_layer  = 0;

    int start_layer[$];
    int start_cyc[$];
    int swap_cyc[$];

    int w_cyc;
    int t_cyc;
    int s_cyc;

    cnn_layer_sequencer #(
        .NUM_LAYERS (4),
        .TMO_W      (24)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .chipselect  (chipselect),
        .write       (write),
        .read        (read),
        .address     (address),
        .writedata   (writedata),
        .readdata    (readdata),
        .loaded      (loaded),
        .layer_start (layer_start),
        .layer_done  (layer_done),
        .buf_swap    (buf_swap),
        .irq         (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock; also plays the layer engines and logs start/swap pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        cycle = cycle + 1;
        layer_done = '0;
        if (due_valid && (cycle == due_cycle)) begin
            layer_done[due_layer] = 1'b1;
            due_valid = 1'b0;
        end
        if (buf_swap) swap_cyc.push_back(cycle);
        for (int i = 0; i < 4; i++) begin
            if (layer_start[i]) begin
                start_layer.push_back(i);
                start_cyc.push_back(cycle);
                if (auto_en && !never_mask[i]) begin
                    due_valid = 1'b1;
                    due_cycle = cycle + 10;
                    due_layer = i;
                end
            end
        end
    endtask

    task automatic clear_logs();
        start_layer.delete();
        start_cyc.delete();
        swap_cyc.delete();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = 8'h00;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
        tick();
        chipselect = 1'b0;
        read       = 1'b0;
        d          = readdata;
    endtask

    task automatic read_check(input string tag, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        check(tag, 32'(d), 32'(exp));
    endtask

    task automatic wait_irq(input string tag, input int budget);
        int n = 0;
        while (!irq && (n < budget)) begin
            tick();
            n++;
        end
        check(tag, 32'(irq), 32'd1);
    endtask

    task automatic wait_start(input string tag, input int count, input int budget);
        int n = 0;
        while ((start_layer.size() < count) && (n < budget)) begin
            tick();
            n++;
        end
        check(tag, 32'(start_layer.size() >= count), 32'd1);
    endtask

    task automatic check_full_run(input string tag);
        check({tag, "_nstart"}, 32'(start_layer.size()), 32'd4);
        for (int i = 0; i < start_layer.size(); i++) begin
            check({tag, "_order"}, 32'(start_layer[i]), 32'(i));
        end
        check({tag, "_nswap"}, 32'(swap_cyc.size()), 32'd4);
        read_check({tag, "_status"}, 2'd1, 8'hA5);
    endtask

    initial begin
        reset      = 1'b1;
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        address    = 2'd0;
        writedata  = 8'h00;
        loaded     = 5'b00000;
        layer_done = 4'b0000;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        check("rst_readdata", 32'(readdata), 32'h00);
        check("rst_start", 32'(layer_start), 32'h0);
        check("rst_swap", 32'(buf_swap), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        read_check("rst_status", 2'd1, 8'h00);
        read_check("rst_tmo", 2'd2, 8'hFF);
        read_check("rst_errcode", 2'd3, 8'h00);

        // Full run: engines answer 10 cycles after each start.
        loaded  = 5'b11111;
        auto_en = 1'b1;
        clear_logs();
        w_cyc = cycle;
        bus_write(2'd0, 8'h01);
        wait_irq("run1_irq", 500);
        check_full_run("run1");
        if (start_cyc.size() >= 2) begin
            check("run1_go_lat", 32'(start_cyc[0] - w_cyc), 32'd3);
            check("run1_start_gap", 32'(start_cyc[1] - start_cyc[0]), 32'd13);
        end
        if ((swap_cyc.size() >= 1) && (start_cyc.size() >= 1)) begin
            check("run1_swap_lat", 32'(swap_cyc[0] - start_cyc[0]), 32'd12);
        end
        read_check("run1_err", 2'd3, 8'h00);

        bus_write(2'd0, 8'h04);
        check("irqclr_irq", 32'(irq), 32'd0);
        read_check("irqclr_status", 2'd1, 8'h25);

        // Rerun from DONE with weight bank 3 missing for 50 cycles.
        loaded = 5'b10111;
        clear_logs();
        bus_write(2'd0, 8'h01);
        repeat (50) tick();
        check("load_nostart", 32'(start_layer.size()), 32'd0);
        loaded = 5'b11111;
        t_cyc  = cycle;
        wait_start("load_start", 1, 20);
        if (start_cyc.size() >= 1) begin
            check("load_lat", 32'(start_cyc[0] - t_cyc), 32'd2);
        end
        wait_irq("load_irq", 500);
        bus_write(2'd0, 8'h04);

        // Watchdog: TMO=1 gives a 65536-cycle limit, layer 1 never answers.
        bus_write(2'd2, 8'h01);
        never_mask = 4'b0010;
        clear_logs();
        bus_write(2'd0, 8'h01);
        wait_start("wd_start", 2, 100);
        s_cyc = (start_cyc.size() >= 2) ? start_cyc[1] : cycle;
        wait_irq("wd_irq", 70000);
        check("wd_latency", 32'(cycle - s_cyc), 32'd65536);
        read_check("wd_errcode", 2'd3, 8'h01);
        read_check("wd_status", 2'd1, 8'hCE);
        bus_write(2'd0, 8'h04);
        bus_write(2'd2, 8'hFF);
        never_mask = 4'b0000;

        // Stray done from layer 2 while layer 0 runs.
        auto_en = 1'b0;
        clear_logs();
        bus_write(2'd0, 8'h01);
        wait_start("unx_start", 1, 20);
        tick();
        tick();
        layer_done = 4'b0100;
        tick();
        tick();
        tick();
        layer_done = 4'b0001;
        tick();
        repeat (5) tick();
        check("unx_irq", 32'(irq), 32'd1);
        read_check("unx_errcode", 2'd3, 8'h02);
        read_check("unx_status", 2'd1, 8'hC6);
        check("unx_noswap", 32'(swap_cyc.size()), 32'd0);
        check("unx_nstart", 32'(start_layer.size()), 32'd1);
        bus_write(2'd0, 8'h04);

        // Abort during layer 2, then GO+ABORT in one byte, then clear and rerun.
        auto_en = 1'b1;
        clear_logs();
        bus_write(2'd0, 8'h01);
        wait_start("abt_start", 3, 200);
        repeat (3) tick();
        bus_write(2'd0, 8'h02);
        due_valid = 1'b0;
        check("abt_irq", 32'(irq), 32'd1);
        read_check("abt_errcode", 2'd3, 8'h03);
        read_check("abt_status", 2'd1, 8'hD6);
        bus_write(2'd0, 8'h03);
        read_check("abt_goabort", 2'd1, 8'hD6);
        bus_write(2'd0, 8'h04);
        check("abt_irqclr", 32'(irq), 32'd0);
        read_check("abt_status_clr", 2'd1, 8'h56);
        repeat (20) tick();
        clear_logs();
        bus_write(2'd0, 8'h01);
        wait_irq("rerun_irq", 500);
        check_full_run("rerun");
        read_check("rerun_err", 2'd3, 8'h00);

        // Reset while in SWAP.
        bus_write(2'd0, 8'h04);
        bus_write(2'd2, 8'h20);
        clear_logs();
        bus_write(2'd0, 8'h01);
        wait_start("rsw_start", 1, 20);
        s_cyc = (start_cyc.size() >= 1) ? start_cyc[0] : cycle;
        while (cycle < s_cyc + 11) tick();
        reset = 1'b1;
        tick();
        check("rsw_swap", 32'(buf_swap), 32'd0);
        check("rsw_start0", 32'(layer_start), 32'd0);
        check("rsw_nswap", 32'(swap_cyc.size()), 32'd0);
        reset     = 1'b0;
        due_valid = 1'b0;
        read_check("rsw_status", 2'd1, 8'h00);
        read_check("rsw_tmo", 2'd2, 8'hFF);
        read_check("rsw_errcode", 2'd3, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
